// File: rtl/bird_position.sv
// bird_position: turns rising edges of the slow game tick into game steps and
// moves the bird one row per step. A flap makes the bird climb FLAP_ROWS rows;
// otherwise it falls one row per step. Reaching the bottom row is a crash,
// and the crash holds until reset.
module bird_position #(
    parameter int ROWS      = 16,
    parameter int ROW_W     = 4,
    parameter int START_ROW = 8,
    parameter int FLAP_ROWS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             flap,
    output logic [ROW_W-1:0] bird_row,
    output logic [ROWS-1:0]  row_onehot,
    output logic             running,
    output logic             crash
);

    // rise_left never exceeds FLAP_ROWS-1; keep at least one bit
    localparam int RL_W = (FLAP_ROWS > 1) ? $clog2(FLAP_ROWS) : 1;
    localparam logic [RL_W-1:0]  RISE_INIT = RL_W'(FLAP_ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_START = ROW_W'(START_ROW);
    localparam logic [ROW_W-1:0] ROW_BOT   = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2,
        DEAD = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [RL_W-1:0]   rise_left_q, rise_left_d;
    logic              flap_pending_q, flap_pending_d;
    logic              tick_q;
    logic              flap_s1_q, flap_s2_q, flap_s3_q;

    logic              tick_rise;
    logic              flap_rise;
    logic              flap_any;
    logic [ROW_W-1:0]  row_up;
    logic [ROW_W-1:0]  row_down;

    // Edge detectors: a tick already high when reset releases counts as a rise
    // because tick_q comes out of reset at 0.
    assign tick_rise = tick & ~tick_q;
    assign flap_rise = flap_s2_q & ~flap_s3_q;
    assign flap_any  = flap_pending_q | flap_rise;

    // Climbing saturates at the top row; there is no ceiling crash.
    assign row_up   = (row_q == '0) ? '0 : row_q - 1'b1;
    assign row_down = row_q + 1'b1;

    // Input capture: tick delay for edge detect, flap through a 3-flop synchronizer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q    <= 1'b0;
            flap_s1_q <= 1'b0;
            flap_s2_q <= 1'b0;
            flap_s3_q <= 1'b0;
        end else begin
            tick_q    <= tick;
            flap_s1_q <= flap;
            flap_s2_q <= flap_s1_q;
            flap_s3_q <= flap_s2_q;
        end
    end

    // Game state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            row_q          <= ROW_START;
            rise_left_q    <= '0;
            flap_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            rise_left_q    <= rise_left_d;
            flap_pending_q <= flap_pending_d;
        end
    end

    // Next-state: a flap seen between ticks is remembered until the next tick
    // consumes it; all movement happens only on a tick edge.
    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        rise_left_d    = rise_left_q;
        flap_pending_d = flap_pending_q;

        if (tick_rise)
            flap_pending_d = 1'b0;
        else if (flap_rise)
            flap_pending_d = 1'b1;

        if (tick_rise) begin
            unique case (state_q)
                IDLE: begin
                    if (flap_any) begin
                        row_d       = row_up;
                        rise_left_d = RISE_INIT;
                        state_d     = RISE;
                    end
                end
                RISE: begin
                    if (flap_any) begin
                        row_d       = row_up;
                        rise_left_d = RISE_INIT;
                    end else if (rise_left_q != '0) begin
                        row_d       = row_up;
                        rise_left_d = rise_left_q - 1'b1;
                    end else begin
                        row_d       = row_down;
                        state_d     = (row_down == ROW_BOT) ? DEAD : FALL;
                    end
                end
                FALL: begin
                    if (flap_any) begin
                        row_d       = row_up;
                        rise_left_d = RISE_INIT;
                        state_d     = RISE;
                    end else begin
                        row_d       = row_down;
                        state_d     = (row_down == ROW_BOT) ? DEAD : FALL;
                    end
                end
                DEAD: ;
                default: ;
            endcase
        end

        // A crashed bird is frozen and ignores flaps entirely
        if (state_q == DEAD) begin
            state_d        = DEAD;
            row_d          = row_q;
            flap_pending_d = 1'b0;
        end
    end

    // Outputs are pure decodes of registered state
    assign bird_row   = row_q;
    assign row_onehot = ROWS'(1) << row_q;
    assign running    = (state_q == RISE) || (state_q == FALL);
    assign crash      = (state_q == DEAD);

endmodule

// File: tb/tb_bird_position.sv
module tb_bird_position;

    localparam int ROWS      = 16;
    localparam int ROW_W     = 4;
    localparam int START_ROW = 8;
    localparam int FLAP_ROWS = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             tick = 1'b0;
    logic             flap = 1'b0;
    logic [ROW_W-1:0] bird_row;
    logic [ROWS-1:0]  row_onehot;
    logic             running;
    logic             crash;

    int n_cmp = 0;
    int n_err = 0;

    bird_position #(
        .ROWS(ROWS), .ROW_W(ROW_W), .START_ROW(START_ROW), .FLAP_ROWS(FLAP_ROWS)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .flap(flap),
        .bird_row(bird_row), .row_onehot(row_onehot),
        .running(running), .crash(crash)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 climbing, 2 falling, 3 crashed
    int m_row, m_mode, m_left, m_cyc, m_press;
    bit m_pend, m_tprev, m_fprev;

    always @(posedge clk or negedge reset) begin
        int r, md, lf;
        bit pd, step, fl_evt, fl, went_down;
        if (!reset) begin
            m_row   <= START_ROW;
            m_mode  <= 0;
            m_left  <= 0;
            m_pend  <= 1'b0;
            m_tprev <= 1'b0;
            m_fprev <= 1'b0;
            m_press <= -100;
            m_cyc   <= 0;
        end else begin
            r = m_row; md = m_mode; lf = m_left; pd = m_pend;
            step   = tick && !m_tprev;
            // a button press becomes visible to the game two clocks after it is sampled
            fl_evt = (m_cyc - m_press == 2);
            fl     = pd || fl_evt;
            went_down = 1'b0;
            if (md == 3) begin
                pd = 1'b0;
            end else begin
                if (step) pd = 1'b0;
                else if (fl_evt) pd = 1'b1;
                if (step) begin
                    if (fl && md != 3) begin
                        r = (r > 0) ? r - 1 : 0;
                        lf = FLAP_ROWS - 1;
                        md = 1;
                    end else if (md == 1 && lf > 0) begin
                        r = (r > 0) ? r - 1 : 0;
                        lf = lf - 1;
                    end else if (md == 1 || md == 2) begin
                        r = r + 1;
                        md = 2;
                        went_down = 1'b1;
                    end
                    if (went_down && r == ROWS - 1) md = 3;
                end
            end
            m_row   <= r;
            m_mode  <= md;
            m_left  <= lf;
            m_pend  <= pd;
            m_tprev <= tick;
            m_fprev <= flap;
            if (flap && !m_fprev) m_press <= m_cyc;
            m_cyc   <= m_cyc + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [ROWS-1:0] exp_oh;
        exp_oh = '0;
        exp_oh[m_row] = 1'b1;
        n_cmp++;
        if (bird_row !== ROW_W'(m_row) || row_onehot !== exp_oh ||
            running !== (m_mode == 1 || m_mode == 2) || crash !== (m_mode == 3)) begin
            n_err++;
            $display("FAIL model t=%0t: row=%0d oh=%h run=%b crash=%b, want row=%0d oh=%h run=%b crash=%b",
                     $time, bird_row, row_onehot, running, crash,
                     m_row, exp_oh, (m_mode == 1 || m_mode == 2), (m_mode == 3));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic step();
        tick = 1'b1; cyc(2);
        tick = 1'b0; cyc(2);
    endtask

    task automatic press();
        flap = 1'b1; cyc(3);
        flap = 1'b0; cyc(2);
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; tick = 1'b0; flap = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(1);
    endtask

    initial begin
        cyc(2);
        reset = 1'b1;
        cyc(1);
        chk("reset_row", bird_row, 8);
        chk("reset_onehot", row_onehot, 16'h0100);
        chk("reset_run", running, 0);
        chk("reset_crash", crash, 0);

        // idle hold
        for (int i = 0; i < 5; i++) step();
        chk("idle_row", bird_row, 8);
        chk("idle_run", running, 0);

        // flap arc 7,6,7,8
        press();
        step(); chk("arc1", bird_row, 7); chk("arc1_run", running, 1);
        step(); chk("arc2", bird_row, 6);
        step(); chk("arc3", bird_row, 7);
        step(); chk("arc4", bird_row, 8); chk("arc4_run", running, 1);

        // fall to crash
        for (int i = 0; i < 6; i++) step();
        chk("fall_14", bird_row, 14); chk("fall_14_crash", crash, 0);
        step();
        chk("fall_15", bird_row, 15); chk("crash_set", crash, 1); chk("crash_run", running, 0);
        step(); press(); step(); step();
        chk("dead_row", bird_row, 15); chk("dead_crash", crash, 1);

        // ceiling saturate
        do_reset();
        for (int i = 0; i < 8; i++) begin press(); step(); end
        chk("ceil_reach", bird_row, 0);
        for (int i = 0; i < 3; i++) begin press(); step(); end
        chk("ceil_hold", bird_row, 0);
        step(); chk("ceil_last_up", bird_row, 0);
        step(); chk("ceil_down", bird_row, 1);

        // flap rise coincident with tick rise
        do_reset();
        flap = 1'b1; cyc(2);
        tick = 1'b1; cyc(1);
        flap = 1'b0; cyc(1);
        tick = 1'b0; cyc(2);
        chk("coin_up", bird_row, 7);
        step(); chk("coin_next", bird_row, 6);
        step(); chk("coin_fall", bird_row, 7);

        // flap held across 4 ticks
        do_reset();
        flap = 1'b1; cyc(3);
        step(); step(); step(); step();
        chk("held_flap", bird_row, 8);
        flap = 1'b0; cyc(2);

        // tick held high for 200 cycles is one step (bird is falling here)
        tick = 1'b1; cyc(200);
        tick = 1'b0; cyc(2);
        chk("held_tick", bird_row, 9);

        // async reset mid-rise
        do_reset();
        press(); step(); step();
        chk("pre_reset", bird_row, 6);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("async_row", bird_row, 8);
        chk("async_crash", crash, 0);
        chk("async_run", running, 0);
        cyc(1);
        reset = 1'b1;
        cyc(1);
        step();
        chk("post_reset_idle", bird_row, 8);
        chk("post_reset_run", running, 0);

        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

endmodule

// File: doc/bird_position.md
Name: bird_position

Overview:
Downstream consumer of the 1/256 slow-tick divider output in the game datapath. Converts the tick's rising edges into discrete game steps and updates the bird's vertical position. The bird falls one row per step, or rises FLAP_ROWS rows after a flap button press. Drives the LED-matrix row select and a crash flag for the game controller.

Parameters:
ROWS, 16, number of matrix rows; row 0 = top, ROWS-1 = bottom.
ROW_W, 4, width of the row index; must satisfy 2^ROW_W >= ROWS.
START_ROW, 8, row loaded on reset.
FLAP_ROWS, 2, number of upward steps per flap; must be >= 1.

Ports:
clk  in  1  system clock; tick and all state are synchronous to it.
reset  in  1  asynchronous, active-low; asserted at 0.
tick  in  1  slow-clock level from the divider; high for many cycles; only its rising edge is used.
flap  in  1  raw flap button, active-high, asynchronous to clk.
bird_row  out  ROW_W  current bird row index.
row_onehot  out  ROWS  1 << bird_row, decoded combinationally from the bird_row register.
running  out  1  high in states RISE and FALL.
crash  out  1  high in state DEAD; sticky until reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, bird_row=START_ROW, rise_left=0, flap_pending=0.
  - tick_q, flap_s1, flap_s2 and flap_s3 all cleared to 0.
  - crash=0, running=0.
- Tick edge detection:
  - tick_q <= tick; tick_rise = tick & ~tick_q.
  - Exactly one step per low-to-high transition of tick.
  - A tick already high at reset release counts as one rise.
- Flap path:
  - Three-flop chain flap_s1 -> flap_s2 -> flap_s3.
  - flap_rise = flap_s2 & ~flap_s3, a one-cycle pulse two cycles after the pin rises.
  - Holding flap high produces one flap_rise only.
- flap_pending:
  - Set on flap_rise.
  - Cleared on any cycle where tick_rise=1.
  - flap_any = flap_pending | flap_rise, so a flap that coincides with a tick edge is counted for that tick.
- Position updates: all occur on the clock edge where tick_rise=1, so bird_row changes one cycle after tick goes high. There is no change on other cycles.
  - UP: bird_row-1, saturating at 0 (no ceiling crash).
  - DOWN: bird_row+1.
- FSM, evaluated only when tick_rise=1; DEAD ignores tick_rise:
  - IDLE:
    - flap_any: UP, rise_left=FLAP_ROWS-1, go to RISE.
    - Otherwise: hold.
  - RISE:
    - flap_any: UP, rise_left=FLAP_ROWS-1 (restart the rise).
    - Else if rise_left>0: UP, rise_left-1.
    - Else: DOWN, go to FALL.
  - FALL:
    - flap_any: UP, rise_left=FLAP_ROWS-1, go to RISE.
    - Otherwise: DOWN.
  - Bottom: if a DOWN produces bird_row == ROWS-1 (from RISE or FALL), go to DEAD. crash rises on the same edge that bird_row becomes ROWS-1.
  - DEAD: bird_row frozen at ROWS-1; tick and flap are ignored; flap_pending is held at 0. Exit only via reset.
- Ceiling: UP at row 0 keeps row 0. rise_left still decrements, so a full rise at the ceiling ends with a DOWN to row 1.
- Reset mid-operation: immediate return to reset values in any state, including a pending flap.
- Outputs are registered (bird_row, crash, running) or decoded directly from bird_row (row_onehot). No other combinational path from an input to an output.

Test Plan:
- Idle hold: release reset, apply 5 tick rises with no flap -> bird_row=8, row_onehot=16'h0100, running=0, crash=0 throughout.
- Flap arc: pulse flap 3 cycles, then tick rises 1..4 -> bird_row 7, 6, 7, 8. running=1 from the first step; state sequence RISE, RISE, FALL, FALL.
- Fall to crash: continue ticks without flap from row 8 -> crash=1 on the edge bird_row becomes 15 (7th DOWN). Further ticks and flap presses leave bird_row=15, crash=1, running=0.
- Ceiling saturate: flap before every tick from row 8 -> bird_row reaches 0 after 8 ticks and stays 0 for 3 more flapped ticks. Then 2 unflapped ticks -> 0, then 1.
- Edge coincidence and held inputs:
  - flap_rise on the same cycle as tick_rise -> that tick is UP and flap_pending is 0 afterwards.
  - flap held high across 4 ticks -> only the first tick is a flap; the following ticks follow the rise/fall rules.
  - tick held high 200 cycles -> one step.
- Async reset mid-RISE: drive reset=0 between clock edges while bird_row=6 -> bird_row=8, crash=0, running=0 before the next clk edge. After release, a tick with no flap leaves row 8 (IDLE).
